// File: rtl/instr_encoder_if.sv
// Instruction encoder and issue buffer: packs loader commands into ID-stage
// instruction words, queues them in a small FIFO and issues them in order.
module instr_encoder_if #(
    parameter int ARQ   = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [23:0]    cmd_imm,
    output logic           instr_valid,
    input  logic           instr_ready,
    output logic [ARQ-3:0] instr,
    output logic           illegal_op,
    output logic [15:0]    issued_cnt
);

    localparam int IW = ARQ - 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] OPC_NOP  = 4'b0101;
    localparam logic [2:0] OP_SETN  = 3'd2;
    localparam logic [2:0] OP_LAST  = 3'd5;

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          op_illegal;
    logic [IW-1:0] enc_word;
    logic [IW-1:0] nop_word;

    assign nop_word = {OPC_NOP, {(IW-4){1'b0}}};

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign cmd_ready   = !full;
    assign instr_valid = !empty;
    assign push        = cmd_valid && !full;
    assign pop         = !empty && instr_ready;

    // Output is the stored head entry; an empty queue shows the NOP word.
    assign instr = empty ? nop_word : mem[rd_ptr];

    // Encode the incoming command; illegal opcodes become NOP and raise a flag.
    always_comb begin
        enc_word   = '0;
        op_illegal = 1'b0;
        if (cmd_op > OP_LAST) begin
            enc_word[IW-1 -: 4] = OPC_NOP;
            op_illegal          = 1'b1;
        end else begin
            enc_word[IW-1 -: 4] = {1'b0, cmd_op};
            if (cmd_op == OP_SETN) begin
                enc_word[23:0] = cmd_imm;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, written with the encoded word on each accepted command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // Sticky illegal-opcode flag and wrapping count of issued words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_op <= 1'b0;
            issued_cnt <= '0;
        end else begin
            if (push && op_illegal) begin
                illegal_op <= 1'b1;
            end
            if (pop) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_if.sv
// Self-checking bench for instr_encoder_if: queue-based reference model checked
// every cycle, directed literal checks, then randomized traffic with resets.
module tb_instr_encoder_if;

    localparam int          DEPTH = 4;
    localparam logic [29:0] NOP   = 30'h1400_0000;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        cmd_valid   = 1'b0;
    logic        instr_ready = 1'b0;
    logic [2:0]  cmd_op      = '0;
    logic [23:0] cmd_imm     = '0;
    logic        cmd_ready;
    logic        instr_valid;
    logic        illegal_op;
    logic [29:0] instr;
    logic [15:0] issued_cnt;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [29:0] mq[$];
    logic [15:0] m_cnt = '0;
    logic        m_ill = 1'b0;
    bit          m_full;
    bit          m_push;
    bit          m_pop;

    // words observed leaving the DUT
    logic [29:0] log_q[$];

    instr_encoder_if #(.ARQ(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_imm     (cmd_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .illegal_op  (illegal_op),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] model_word(input logic [2:0] op, input logic [23:0] imm);
        int o;
        o = int'(op);
        if (o > 5) return NOP;
        return (30'(o) << 26) | ((o == 2) ? 30'(imm) : 30'd0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of words, issue count and sticky flag.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_cnt = '0;
            m_ill = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_push = cmd_valid && !m_full;
            m_pop  = (mq.size() != 0) && instr_ready;
            if (m_pop) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (m_push) begin
                mq.push_back(model_word(cmd_op, cmd_imm));
                if (cmd_op > 3'd5) m_ill = 1'b1;
            end
        end
    end

    // Compare DUT against the model mid-cycle and record issued words.
    always @(negedge clk) begin
        if (rst) begin
            chk("cmd_ready",   32'(cmd_ready),   32'(mq.size() < DEPTH));
            chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
            chk("instr",       32'(instr),       32'((mq.size() != 0) ? mq[0] : NOP));
            chk("illegal_op",  32'(illegal_op),  32'(m_ill));
            chk("issued_cnt",  32'(issued_cnt),  32'(m_cnt));
            if (instr_valid && instr_ready) log_q.push_back(instr);
        end
    end

    task automatic step(input logic v, input logic [2:0] op, input logic [23:0] imm, input logic rdy);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_imm     = imm;
        instr_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b0, 3'd0, 24'h0, rdy);
    endtask

    task automatic do_reset;
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [29:0] exp);
        chk(nm, 32'((idx < log_q.size()) ? log_q[idx] : 30'h3FFF_FFFF), 32'(exp));
    endtask

    logic [2:0]  ops5 [5];
    logic [29:0] exp5 [5];
    int unsigned rdy_pct;

    initial begin
        rst = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        idle(1, 1'b0);

        // reset state
        chk("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr",       32'(instr),       32'h1400_0000);
        chk("rst_issued_cnt",  32'(issued_cnt),  32'd0);
        chk("rst_illegal",     32'(illegal_op),  32'd0);

        // SETN with immediate, one-cycle latency
        log_q.delete();
        step(1'b1, 3'd2, 24'h000008, 1'b1);
        cmd_valid = 1'b0;
        #1;
        chk("setn_word",  32'(instr),       32'h0800_0008);
        chk("setn_valid", 32'(instr_valid), 32'd1);
        step(1'b0, 3'd0, 24'h0, 1'b1);
        chk("setn_cnt",   32'(issued_cnt),  32'd1);
        chk_log("setn_log", 0, 30'h0800_0008);

        // back-to-back legal opcodes, immediate ignored
        do_reset();
        log_q.delete();
        ops5 = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
        exp5 = '{30'h0000_0000, 30'h0400_0000, 30'h0C00_0000, 30'h1000_0000, 30'h1400_0000};
        for (int i = 0; i < 5; i++) step(1'b1, ops5[i], 24'hFFFFFF, 1'b1);
        idle(3, 1'b1);
        chk("b2b_count", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk_log("b2b_word", i, exp5[i]);
        chk("b2b_cnt", 32'(issued_cnt), 32'd5);

        // fill to full with ID stalled, then drain
        do_reset();
        log_q.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 24'h000002, 1'b0);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        step(1'b1, 3'd4, 24'h0, 1'b0);
        step(1'b1, 3'd4, 24'h0, 1'b0);
        chk("full_hold_instr", 32'(instr),       32'h0000_0000);
        chk("full_hold_valid", 32'(instr_valid), 32'd1);
        chk("full_hold_ready", 32'(cmd_ready),   32'd0);
        step(1'b1, 3'd4, 24'h0, 1'b1);
        chk("full_reready", 32'(cmd_ready), 32'd1);
        step(1'b1, 3'd4, 24'h0, 1'b1);
        idle(6, 1'b1);
        exp5 = '{30'h0000_0000, 30'h0400_0000, 30'h0800_0002, 30'h0C00_0000, 30'h1000_0000};
        chk("full_count", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk_log("full_word", i, exp5[i]);
        chk("full_cnt", 32'(issued_cnt), 32'd5);

        // illegal opcode encodes as NOP and sets the sticky flag
        do_reset();
        log_q.delete();
        step(1'b1, 3'd7, 24'h123456, 1'b1);
        cmd_valid = 1'b0;
        #1;
        chk("ill_flag", 32'(illegal_op), 32'd1);
        idle(2, 1'b1);
        chk("ill_count", 32'(log_q.size()), 32'd1);
        chk_log("ill_word", 0, NOP);
        step(1'b1, 3'd2, 24'h000005, 1'b1);
        step(1'b1, 3'd0, 24'h0, 1'b1);
        idle(3, 1'b1);
        chk("ill_sticky", 32'(illegal_op), 32'd1);

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 24'h0, 1'b0);
        chk("mid_valid_pre", 32'(instr_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_cmd_ready", 32'(cmd_ready),   32'd1);
        chk("mid_valid",     32'(instr_valid), 32'd0);
        chk("mid_instr",     32'(instr),       32'h1400_0000);
        chk("mid_cnt",       32'(issued_cnt),  32'd0);
        chk("mid_illegal",   32'(illegal_op),  32'd0);
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        log_q.delete();
        idle(4, 1'b1);
        chk("mid_no_issue", 32'(log_q.size()), 32'd0);
        chk("mid_cnt_post", 32'(issued_cnt),   32'd0);

        // randomized traffic with varying back-pressure and sporadic resets
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) rdy_pct = $urandom_range(10, 100);
            step(1'($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)),
                 24'($urandom), 1'($urandom_range(0, 99) < rdy_pct));
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
